// File: rtl/bus_initiator_pkg.sv
// Shared definitions for the byte-serial bus initiator: RV32I load/store widths,
// byte-count encodings, FSM state codes, the request payload and small decode helpers.
package bus_initiator_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned BHW_W = 3;

  // RV32I funct3 width codes
  localparam logic [F3_W-1:0] F3_B  = 3'b000;
  localparam logic [F3_W-1:0] F3_H  = 3'b001;
  localparam logic [F3_W-1:0] F3_W_ = 3'b010;
  localparam logic [F3_W-1:0] F3_BU = 3'b100;
  localparam logic [F3_W-1:0] F3_HU = 3'b101;

  // Byte count carried on o_bhw
  localparam logic [BHW_W-1:0] BHW_BYTE = 3'b001;
  localparam logic [BHW_W-1:0] BHW_HALF = 3'b010;
  localparam logic [BHW_W-1:0] BHW_WORD = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RSP = 2'd1,
    ST_RESP     = 2'd2
  } state_e;

  // Request fields held on the bus for the duration of a transaction
  typedef struct packed {
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  data;
    logic [BHW_W-1:0] bhw;
    logic             write_notread;
  } bus_req_t;

  // Reserved widths, and unsigned widths used as stores, never reach the bus
  function automatic logic f3_illegal(input logic [F3_W-1:0] f3, input logic we);
    logic ill;
    case (f3)
      F3_B, F3_H, F3_W_: ill = 1'b0;
      F3_BU, F3_HU:      ill = we;
      default:           ill = 1'b1;
    endcase
    return ill;
  endfunction

  function automatic logic [BHW_W-1:0] f3_bhw(input logic [F3_W-1:0] f3);
    logic [BHW_W-1:0] b;
    case (f3[1:0])
      2'b00:   b = BHW_BYTE;
      2'b01:   b = BHW_HALF;
      default: b = BHW_WORD;
    endcase
    return b;
  endfunction

  // Zero the lanes at and above the byte count
  function automatic logic [XLEN-1:0] lane_mask(input logic [BHW_W-1:0] bhw,
                                                input logic [XLEN-1:0]  d);
    logic [XLEN-1:0] m;
    case (bhw)
      BHW_BYTE: m = {24'h0, d[7:0]};
      BHW_HALF: m = {16'h0, d[15:0]};
      default:  m = d;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bus_initiator_load_extend.sv
// Load data extension unit, shared with the writeback stage.
//   funct3 : RV32I load width
//   raw    : bytes as returned by the bus, byte0 in [7:0]
//   ext_c  : sign/zero-extended result (combinational)
module bus_initiator_load_extend
  import bus_initiator_pkg::*;
(
  input  logic [F3_W-1:0] funct3,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] ext_c
);

  always_comb begin
    ext_c = raw;
    case (funct3)
      F3_B:    ext_c = {{24{raw[7]}}, raw[7:0]};
      F3_H:    ext_c = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   ext_c = {24'h0, raw[7:0]};
      F3_HU:   ext_c = {16'h0, raw[15:0]};
      default: ext_c = raw;
    endcase
  end

endmodule

// File: rtl/bus_initiator.sv
// CPU-side master for the byte-serial memory bus. Arbitrates fetch and
// load/store requests (load/store wins), issues one transaction at a time,
// waits for the responder strobe or a timeout, and returns extended data.
//   i_clk, i_rst            : clock, async active-high reset
//   i_if_* / o_if_*         : fetch request / completion
//   i_ls_* / o_ls_*         : load/store request / completion (+ error)
//   o_bus_*, o_bhw, o_write_notread, i_bus_* : memory bus
//   o_fault                 : sticky timeout indicator
module bus_initiator
  import bus_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TMO_W          = 11
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_if_req,
  input  logic [XLEN-1:0]  i_if_addr,
  output logic [XLEN-1:0]  o_if_data,
  output logic             o_if_valid,
  input  logic             i_ls_req,
  input  logic             i_ls_we,
  input  logic [F3_W-1:0]  i_ls_funct3,
  input  logic [XLEN-1:0]  i_ls_addr,
  input  logic [XLEN-1:0]  i_ls_wdata,
  output logic [XLEN-1:0]  o_ls_rdata,
  output logic             o_ls_valid,
  output logic             o_ls_err,
  output logic [XLEN-1:0]  o_bus_data,
  output logic [XLEN-1:0]  o_bus_address,
  output logic             o_bus_DV,
  output logic [BHW_W-1:0] o_bhw,
  output logic             o_write_notread,
  input  logic [XLEN-1:0]  i_bus_data,
  input  logic             i_bus_DV,
  output logic             o_fault
);

  state_e          state;
  bus_req_t        req_q;
  logic            is_ls_q;
  logic            we_q;
  logic [F3_W-1:0] f3_q;
  logic [TMO_W-1:0] tmo_q;
  logic [XLEN-1:0] ext_c;
  logic            timeout_hit_c;

  bus_initiator_load_extend u_load_extend (
    .funct3 (f3_q),
    .raw    (i_bus_data),
    .ext_c  (ext_c)
  );

  // Last WAIT_RSP cycle of the budget with no response
  assign timeout_hit_c = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  assign o_bus_address   = req_q.addr;
  assign o_bus_data      = req_q.data;
  assign o_bhw           = req_q.bhw;
  assign o_write_notread = req_q.write_notread;

  // Transaction FSM; strobes and completion pulses default low every cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      req_q      <= '0;
      is_ls_q    <= 1'b0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      tmo_q      <= '0;
      o_bus_DV   <= 1'b0;
      o_if_data  <= '0;
      o_if_valid <= 1'b0;
      o_ls_rdata <= '0;
      o_ls_valid <= 1'b0;
      o_ls_err   <= 1'b0;
      o_fault    <= 1'b0;
    end else begin
      o_bus_DV   <= 1'b0;
      o_if_valid <= 1'b0;
      o_ls_valid <= 1'b0;
      o_ls_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_ls_req) begin
            is_ls_q <= 1'b1;
            we_q    <= i_ls_we;
            f3_q    <= i_ls_funct3;
            if (f3_illegal(i_ls_funct3, i_ls_we)) begin
              o_ls_valid <= 1'b1;
              o_ls_err   <= 1'b1;
              o_ls_rdata <= '0;
              state      <= ST_RESP;
            end else begin
              req_q <= '{addr:          i_ls_addr,
                         data:          i_ls_we ? lane_mask(f3_bhw(i_ls_funct3), i_ls_wdata)
                                                : '0,
                         bhw:           f3_bhw(i_ls_funct3),
                         write_notread: i_ls_we};
              o_bus_DV <= 1'b1;
              tmo_q    <= '0;
              state    <= ST_WAIT_RSP;
            end
          end else if (i_if_req) begin
            is_ls_q  <= 1'b0;
            we_q     <= 1'b0;
            f3_q     <= F3_W_;
            req_q    <= '{addr: i_if_addr, data: '0, bhw: BHW_WORD, write_notread: 1'b0};
            o_bus_DV <= 1'b1;
            tmo_q    <= '0;
            state    <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (i_bus_DV) begin
            state <= ST_RESP;
            if (is_ls_q) begin
              o_ls_valid <= 1'b1;
              o_ls_rdata <= we_q ? '0 : ext_c;
            end else begin
              o_if_valid <= 1'b1;
              o_if_data  <= i_bus_data;
            end
          end else if (timeout_hit_c) begin
            state   <= ST_RESP;
            o_fault <= 1'b1;
            if (is_ls_q) begin
              o_ls_valid <= 1'b1;
              o_ls_err   <= 1'b1;
              o_ls_rdata <= '0;
            end else begin
              o_if_valid <= 1'b1;
              o_if_data  <= '0;
            end
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// Scoreboard bench for bus_initiator: stimulus pushes expected bus requests,
// responder data and completions into queues; a negedge monitor pops and compares.
module tb_bus_initiator;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_if_req = 1'b0;
  logic [31:0] i_if_addr = '0;
  logic [31:0] o_if_data;
  logic        o_if_valid;
  logic        i_ls_req = 1'b0;
  logic        i_ls_we = 1'b0;
  logic [2:0]  i_ls_funct3 = '0;
  logic [31:0] i_ls_addr = '0;
  logic [31:0] i_ls_wdata = '0;
  logic [31:0] o_ls_rdata;
  logic        o_ls_valid;
  logic        o_ls_err;
  logic [31:0] o_bus_data;
  logic [31:0] o_bus_address;
  logic        o_bus_DV;
  logic [2:0]  o_bhw;
  logic        o_write_notread;
  logic [31:0] i_bus_data = '0;
  logic        i_bus_DV = 1'b0;
  logic        o_fault;

  bus_initiator dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_data(o_if_data), .o_if_valid(o_if_valid),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_funct3(i_ls_funct3), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .o_ls_rdata(o_ls_rdata), .o_ls_valid(o_ls_valid), .o_ls_err(o_ls_err),
    .o_bus_data(o_bus_data), .o_bus_address(o_bus_address), .o_bus_DV(o_bus_DV), .o_bhw(o_bhw),
    .o_write_notread(o_write_notread), .i_bus_data(i_bus_data), .i_bus_DV(i_bus_DV),
    .o_fault(o_fault)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] data; logic err; } ls_exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [2:0] bhw; logic wnr; } bus_exp_t;

  ls_exp_t     exp_ls_q[$];
  logic [31:0] exp_if_q[$];
  bus_exp_t    exp_bus_q[$];
  logic [31:0] rsp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rsp_delay = 2;
  bit rsp_mute  = 1'b0;
  int ls_valid_cyc = 0;
  int bus_dv_cyc   = 0;
  int bus_dv_cnt   = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion pulse and bus strobe must match the next queued expectation
  always @(negedge i_clk) begin
    ls_exp_t  le;
    bus_exp_t be;
    logic [31:0] ie;
    if (o_ls_valid) begin
      ls_valid_cyc = cyc;
      if (exp_ls_q.size() == 0) check("unexpected_ls_valid", 32'd1, 32'd0);
      else begin
        le = exp_ls_q.pop_front();
        check("ls_rdata", o_ls_rdata, le.data);
        check("ls_err", 32'(o_ls_err), 32'(le.err));
      end
    end
    if (o_if_valid) begin
      if (exp_if_q.size() == 0) check("unexpected_if_valid", 32'd1, 32'd0);
      else begin
        ie = exp_if_q.pop_front();
        check("if_data", o_if_data, ie);
      end
    end
    if (o_bus_DV) begin
      bus_dv_cnt++;
      bus_dv_cyc = cyc;
      if (exp_bus_q.size() == 0) check("unexpected_bus_dv", 32'd1, 32'd0);
      else begin
        be = exp_bus_q.pop_front();
        check("bus_addr", o_bus_address, be.addr);
        check("bus_data", o_bus_data, be.data);
        check("bus_bhw", 32'(o_bhw), 32'(be.bhw));
        check("bus_wnr", 32'(o_write_notread), 32'(be.wnr));
      end
    end
  end

  // Responder: one stale strobe right after the first reset, then answers each request
  initial begin : responder
    logic [31:0] d;
    @(negedge i_rst);
    @(posedge i_clk); #1;
    i_bus_data = 32'hCAFEF00D; i_bus_DV = 1'b1;
    @(posedge i_clk); #1;
    i_bus_DV = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_bus_DV && !rsp_mute) begin
        d = (rsp_q.size() != 0) ? rsp_q.pop_front() : 32'h0;
        repeat (rsp_delay) @(posedge i_clk);
        #1 i_bus_data = d; i_bus_DV = 1'b1;
        @(posedge i_clk);
        #1 i_bus_DV = 1'b0; i_bus_data = 32'hA5A5A5A5;
      end
    end
  end

  task automatic ls_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output int req_cyc);
    int n;
    @(posedge i_clk); #1;
    i_ls_req = 1'b1; i_ls_we = we; i_ls_funct3 = f3; i_ls_addr = addr; i_ls_wdata = wdata;
    req_cyc = cyc;
    n = 0;
    do begin @(negedge i_clk); n++; end while (!o_ls_valid && n < 2000);
    if (!o_ls_valid) check("ls_wait_bound", 32'd0, 32'd1);
    @(posedge i_clk); #1 i_ls_req = 1'b0;
  endtask

  task automatic if_op(input logic [31:0] addr);
    int n;
    @(posedge i_clk); #1;
    i_if_req = 1'b1; i_if_addr = addr;
    n = 0;
    do begin @(negedge i_clk); n++; end while (!o_if_valid && n < 2000);
    if (!o_if_valid) check("if_wait_bound", 32'd0, 32'd1);
    @(posedge i_clk); #1 i_if_req = 1'b0;
  endtask

  task automatic push_ls(input logic [31:0] addr, input logic [31:0] bdata, input logic [2:0] bhw,
                         input logic wnr, input logic [31:0] rsp, input logic [31:0] rdata);
    exp_bus_q.push_back('{addr: addr, data: bdata, bhw: bhw, wnr: wnr});
    rsp_q.push_back(rsp);
    exp_ls_q.push_back('{data: rdata, err: 1'b0});
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int rc;
    int dv0;
    int n;
    // Reset state
    repeat (2) @(negedge i_clk);
    check("rst_bus_dv", 32'(o_bus_DV), 32'd0);
    check("rst_ls_valid", 32'(o_ls_valid), 32'd0);
    check("rst_if_valid", 32'(o_if_valid), 32'd0);
    check("rst_fault", 32'(o_fault), 32'd0);
    check("rst_bus_addr", o_bus_address, 32'd0);
    check("rst_ls_rdata", o_ls_rdata, 32'd0);
    @(posedge i_clk); #1 i_rst = 1'b0;
    // Stale strobe in IDLE must be ignored
    repeat (4) @(negedge i_clk);
    check("stale_no_bus_dv", 32'(bus_dv_cnt), 32'd0);

    // LW, 5-cycle responder
    rsp_delay = 5;
    push_ls(32'h10, 32'h0, 3'b100, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF);
    ls_op(1'b0, 3'b010, 32'h10, 32'h0, rc);
    rsp_delay = 2;

    // LB / LBU / LH / LHU with junk upper lanes
    push_ls(32'h3, 32'h0, 3'b001, 1'b0, 32'hA5C37E80, 32'hFFFFFF80);
    ls_op(1'b0, 3'b000, 32'h3, 32'h0, rc);
    push_ls(32'h3, 32'h0, 3'b001, 1'b0, 32'hA5C37E80, 32'h00000080);
    ls_op(1'b0, 3'b100, 32'h3, 32'h0, rc);
    push_ls(32'h6, 32'h0, 3'b010, 1'b0, 32'h12348001, 32'hFFFF8001);
    ls_op(1'b0, 3'b001, 32'h6, 32'h0, rc);
    push_ls(32'h6, 32'h0, 3'b010, 1'b0, 32'h12348001, 32'h00008001);
    ls_op(1'b0, 3'b101, 32'h6, 32'h0, rc);

    // Stores: masked bus data, rdata 0
    push_ls(32'h2, 32'h00001234, 3'b010, 1'b1, 32'hFFFFFFFF, 32'h0);
    ls_op(1'b1, 3'b001, 32'h2, 32'hABCD1234, rc);
    push_ls(32'h20, 32'h89ABCDEF, 3'b100, 1'b1, 32'hFFFFFFFF, 32'h0);
    ls_op(1'b1, 3'b010, 32'h20, 32'h89ABCDEF, rc);

    // Fetch alone
    exp_bus_q.push_back('{addr: 32'h100, data: 32'h0, bhw: 3'b100, wnr: 1'b0});
    rsp_q.push_back(32'h00112233);
    exp_if_q.push_back(32'h00112233);
    if_op(32'h100);

    // Minimum latency: req to valid in 3 cycles
    rsp_delay = 1;
    push_ls(32'h8, 32'h0, 3'b100, 1'b0, 32'h76543210, 32'h76543210);
    ls_op(1'b0, 3'b010, 32'h8, 32'h0, rc);
    check("min_latency", 32'(ls_valid_cyc - rc), 32'd3);
    rsp_delay = 2;

    // Simultaneous requests: load/store first, fetch right after its RESP
    dv0 = bus_dv_cnt;
    push_ls(32'h44, 32'h0, 3'b100, 1'b0, 32'h0BADF00D, 32'h0BADF00D);
    exp_bus_q.push_back('{addr: 32'h200, data: 32'h0, bhw: 3'b100, wnr: 1'b0});
    rsp_q.push_back(32'h13579BDF);
    exp_if_q.push_back(32'h13579BDF);
    fork
      ls_op(1'b0, 3'b010, 32'h44, 32'h0, rc);
      if_op(32'h200);
    join
    check("arb_fetch_gap", 32'(bus_dv_cyc - ls_valid_cyc), 32'd2);
    check("arb_dv_count", 32'(bus_dv_cnt - dv0), 32'd2);

    // Illegal funct3: no bus transaction, error one cycle after req
    dv0 = bus_dv_cnt;
    exp_ls_q.push_back('{data: 32'h0, err: 1'b1});
    ls_op(1'b0, 3'b011, 32'h50, 32'h0, rc);
    check("illegal_latency", 32'(ls_valid_cyc - rc), 32'd1);
    exp_ls_q.push_back('{data: 32'h0, err: 1'b1});
    ls_op(1'b1, 3'b100, 32'h50, 32'hFF, rc);
    check("illegal_no_dv", 32'(bus_dv_cnt - dv0), 32'd0);
    check("fault_before_tmo", 32'(o_fault), 32'd0);

    // Timeout: silent responder
    rsp_mute = 1'b1;
    exp_bus_q.push_back('{addr: 32'h40, data: 32'h0, bhw: 3'b100, wnr: 1'b0});
    exp_ls_q.push_back('{data: 32'h0, err: 1'b1});
    ls_op(1'b0, 3'b010, 32'h40, 32'h0, rc);
    check("tmo_fault", 32'(o_fault), 32'd1);
    rsp_mute = 1'b0;
    exp_bus_q.push_back('{addr: 32'h104, data: 32'h0, bhw: 3'b100, wnr: 1'b0});
    rsp_q.push_back(32'h44556677);
    exp_if_q.push_back(32'h44556677);
    if_op(32'h104);
    check("fault_sticky", 32'(o_fault), 32'd1);

    // Reset during WAIT_RSP; late strobe ignored
    rsp_delay = 4;
    exp_bus_q.push_back('{addr: 32'h80, data: 32'h0, bhw: 3'b100, wnr: 1'b0});
    rsp_q.push_back(32'h11111111);
    @(posedge i_clk); #1;
    i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_funct3 = 3'b010; i_ls_addr = 32'h80;
    n = 0;
    do begin @(negedge i_clk); n++; end while (!o_bus_DV && n < 20);
    check("rst_mid_dv_seen", 32'(o_bus_DV), 32'd1);
    @(posedge i_clk); #1;
    i_rst = 1'b1; i_ls_req = 1'b0;
    @(negedge i_clk);
    check("rst_mid_addr", o_bus_address, 32'd0);
    check("rst_mid_fault", 32'(o_fault), 32'd0);
    check("rst_mid_bhw", 32'(o_bhw), 32'd0);
    @(posedge i_clk); #1 i_rst = 1'b0;
    dv0 = bus_dv_cnt;
    repeat (8) @(negedge i_clk);
    check("rst_mid_no_valid", 32'(exp_ls_q.size()), 32'd0);
    check("rst_mid_no_dv", 32'(bus_dv_cnt - dv0), 32'd0);
    check("rst_mid_rdata", o_ls_rdata, 32'd0);
    rsp_delay = 2;

    // Normal operation after reset
    push_ls(32'h84, 32'h0, 3'b100, 1'b0, 32'h5A5A5A5A, 32'h5A5A5A5A);
    ls_op(1'b0, 3'b010, 32'h84, 32'h0, rc);

    repeat (4) @(negedge i_clk);
    check("left_ls", 32'(exp_ls_q.size()), 32'd0);
    check("left_if", 32'(exp_if_q.size()), 32'd0);
    check("left_bus", 32'(exp_bus_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
